// File: rtl/aha_clk_gate_ctrl.sv
// Clock-gate controller: idle detection, 4-phase stop handshake with the gated domain,
// registered ICG enable and a saturating count of gated cycles.
module aha_clk_gate_ctrl #(
    parameter int unsigned IDLE_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ACTIVE,
    input  logic              WAKE_REQ,
    input  logic              FORCE_ON,
    input  logic [IDLE_W-1:0] IDLE_LIMIT,
    input  logic              STOP_ACK,
    input  logic              TEST_EN,
    output logic              STOP_REQ,
    output logic              GATE_EN,
    output logic              GATE_TE,
    output logic              CLK_GATED,
    output logic [CNT_W-1:0]  GATED_CNT
);

    typedef enum logic [2:0] {
        StRun,
        StIdle,
        StReq,
        StGated,
        StWake
    } state_e;

    state_e            state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              gate_en_q, gate_en_d;
    logic              stop_req_q, stop_req_d;
    logic              clk_gated_q, clk_gated_d;
    logic [CNT_W-1:0]  gated_cnt_q;
    logic              wake;

    assign wake = WAKE_REQ | FORCE_ON;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            StRun: begin
                if (!ACTIVE && !wake) begin
                    state_d    = StIdle;
                    idle_cnt_d = IDLE_LIMIT;
                end
            end
            StIdle: begin
                if (ACTIVE || wake) begin
                    state_d = StRun;
                end else if (idle_cnt_q == '0) begin
                    state_d = StReq;
                end else begin
                    idle_cnt_d = idle_cnt_q - IDLE_W'(1);
                end
            end
            StReq: begin
                // A wake or new activity overrides an acknowledge arriving in the same cycle.
                if (ACTIVE || wake) begin
                    state_d = StWake;
                end else if (STOP_ACK) begin
                    state_d = StGated;
                end
            end
            StGated: begin
                if (wake) begin
                    state_d = StWake;
                end
            end
            StWake: begin
                if (!STOP_ACK) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Outputs are decoded from the next state so they update on the same edge as the state.
    always_comb begin
        gate_en_d   = (state_d != StGated);
        stop_req_d  = (state_d == StReq) || (state_d == StGated);
        clk_gated_d = (state_d == StGated);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StRun;
            idle_cnt_q  <= '0;
            gate_en_q   <= 1'b1;
            stop_req_q  <= 1'b0;
            clk_gated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            gate_en_q   <= gate_en_d;
            stop_req_q  <= stop_req_d;
            clk_gated_q <= clk_gated_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            gated_cnt_q <= '0;
        end else if (clk_gated_q && !(&gated_cnt_q)) begin
            gated_cnt_q <= gated_cnt_q + CNT_W'(1);
        end
    end

    assign STOP_REQ  = stop_req_q;
    assign GATE_EN   = gate_en_q;
    assign GATE_TE   = TEST_EN;
    assign CLK_GATED = clk_gated_q;
    assign GATED_CNT = gated_cnt_q;

endmodule

// File: tb/tb_aha_clk_gate_ctrl.sv
// Directed bench for aha_clk_gate_ctrl: a behavioural model checked every negedge plus
// hand-computed literal expectations for the key scenarios.
module tb_aha_clk_gate_ctrl;

    localparam int IDLE_W = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int M_RUN   = 0;
    localparam int M_IDLE  = 1;
    localparam int M_REQ   = 2;
    localparam int M_GATED = 3;
    localparam int M_WAKE  = 4;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              ACTIVE;
    logic              WAKE_REQ;
    logic              FORCE_ON;
    logic [IDLE_W-1:0] IDLE_LIMIT;
    logic              STOP_ACK;
    logic              TEST_EN;
    logic              STOP_REQ;
    logic              GATE_EN;
    logic              GATE_TE;
    logic              CLK_GATED;
    logic [CNT_W-1:0]  GATED_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    aha_clk_gate_ctrl #(
        .IDLE_W(IDLE_W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ACTIVE    (ACTIVE),
        .WAKE_REQ  (WAKE_REQ),
        .FORCE_ON  (FORCE_ON),
        .IDLE_LIMIT(IDLE_LIMIT),
        .STOP_ACK  (STOP_ACK),
        .TEST_EN   (TEST_EN),
        .STOP_REQ  (STOP_REQ),
        .GATE_EN   (GATE_EN),
        .GATE_TE   (GATE_TE),
        .CLK_GATED (CLK_GATED),
        .GATED_CNT (GATED_CNT)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode of the controller, idle cycles seen against the latched limit,
    // and an unbounded count of gated cycles that is clipped when compared.
    int m_mode  = M_RUN;
    int m_limit = 0;
    int m_seen  = 0;
    int m_gated = 0;
    bit m_wake;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_mode  <= M_RUN;
            m_seen  <= 0;
            m_limit <= 0;
            m_gated <= 0;
        end else begin
            m_wake = WAKE_REQ || FORCE_ON;
            if (m_mode == M_GATED) m_gated <= m_gated + 1;
            case (m_mode)
                M_RUN:
                    if (!ACTIVE && !m_wake) begin
                        m_mode  <= M_IDLE;
                        m_limit <= int'(IDLE_LIMIT);
                        m_seen  <= 0;
                    end
                M_IDLE:
                    if (ACTIVE || m_wake) m_mode <= M_RUN;
                    else if (m_seen == m_limit) m_mode <= M_REQ;
                    else m_seen <= m_seen + 1;
                M_REQ:
                    if (ACTIVE || m_wake) m_mode <= M_WAKE;
                    else if (STOP_ACK) m_mode <= M_GATED;
                M_GATED:
                    if (m_wake) m_mode <= M_WAKE;
                M_WAKE:
                    if (!STOP_ACK) m_mode <= M_RUN;
                default: m_mode <= M_RUN;
            endcase
        end
    end

    always @(negedge CLK) begin
        check("gate_en_model", GATE_EN, (m_mode != M_GATED));
        check("stop_req_model", STOP_REQ, (m_mode == M_REQ) || (m_mode == M_GATED));
        check("clk_gated_model", CLK_GATED, (m_mode == M_GATED));
        check("gated_cnt_model", GATED_CNT, (m_gated > CNT_MAX) ? CNT_MAX : m_gated);
        check("gate_te_model", GATE_TE, TEST_EN);
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic wait_gated(input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (CLK_GATED) begin
                seen = 1;
                break;
            end
        end
        check(name, seen, 1);
    endtask

    initial begin
        int found;
        ACTIVE     = 1'b0;
        WAKE_REQ   = 1'b0;
        FORCE_ON   = 1'b0;
        IDLE_LIMIT = 8'd4;
        STOP_ACK   = 1'b0;
        TEST_EN    = 1'b0;
        RESET      = 1'b0;
        #1 RESET   = 1'b1;
        #2;
        check("rst_gate_en", GATE_EN, 1);
        check("rst_stop_req", STOP_REQ, 0);
        check("rst_clk_gated", CLK_GATED, 0);
        check("rst_gated_cnt", GATED_CNT, 0);
        TEST_EN = 1'b1;
        #1 check("rst_gate_te_hi", GATE_TE, 1);
        TEST_EN = 1'b0;
        #1 check("rst_gate_te_lo", GATE_TE, 0);
        @(negedge CLK);
        #1 RESET = 1'b0;

        // Idle limit 4: stop request six edges after reset release.
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (STOP_REQ) begin
                found = k;
                break;
            end
        end
        check("stop_req_latency", found, 6);
        STOP_ACK = 1'b1;
        step(1);
        check("ack_gate_en", GATE_EN, 0);
        check("ack_clk_gated", CLK_GATED, 1);
        step(3);
        check("gated_cnt_3", GATED_CNT, 3);

        // Wake from GATED, ack held three more cycles.
        WAKE_REQ = 1'b1;
        step(1);
        check("wake_gate_en", GATE_EN, 1);
        check("wake_stop_req", STOP_REQ, 0);
        check("wake_clk_gated", CLK_GATED, 0);
        check("wake_gated_cnt", GATED_CNT, 4);
        WAKE_REQ = 1'b0;
        step(3);
        STOP_ACK = 1'b0;
        step(1);

        // ACTIVE pulse in IDLE with counter at 2, then a full reload ignoring later limit changes.
        step(3);
        ACTIVE = 1'b1;
        step(1);
        ACTIVE = 1'b0;
        check("pulse_no_stop_req", STOP_REQ, 0);
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k == 1) IDLE_LIMIT = 8'd1;
            if (STOP_REQ) begin
                found = k;
                break;
            end
        end
        check("reload_latency", found, 6);

        // Wake and ack together in REQ: wake wins.
        WAKE_REQ = 1'b1;
        STOP_ACK = 1'b1;
        step(1);
        check("req_wake_stop_req", STOP_REQ, 0);
        check("req_wake_gate_en", GATE_EN, 1);
        WAKE_REQ = 1'b0;
        step(2);
        check("req_wake_held", STOP_REQ, 0);
        STOP_ACK = 1'b0;
        step(1);

        // Saturation of the 4-bit gated counter.
        IDLE_LIMIT = 8'd0;
        STOP_ACK   = 1'b1;
        wait_gated("reach_gated_sat");
        step(20);
        check("gated_cnt_sat", GATED_CNT, 15);
        check("sat_clk_gated", CLK_GATED, 1);

        // Asynchronous reset while gated, ack still high on release.
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("async_gate_en", GATE_EN, 1);
        check("async_stop_req", STOP_REQ, 0);
        check("async_clk_gated", CLK_GATED, 0);
        check("async_gated_cnt", GATED_CNT, 0);
        TEST_EN = 1'b1;
        #1 check("async_gate_te_hi", GATE_TE, 1);
        TEST_EN = 1'b0;
        #1 check("async_gate_te_lo", GATE_TE, 0);
        FORCE_ON = 1'b1;
        @(negedge CLK);
        #1 RESET = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            check("force_gate_en", GATE_EN, 1);
        end

        // FORCE_ON rising while gated pulls the domain back to RUN via WAKE.
        FORCE_ON = 1'b0;
        wait_gated("reach_gated_force");
        FORCE_ON = 1'b1;
        step(1);
        check("force_wake_gate_en", GATE_EN, 1);
        check("force_wake_stop_req", STOP_REQ, 0);
        STOP_ACK = 1'b0;
        step(3);
        check("force_run_gate_en", GATE_EN, 1);
        FORCE_ON = 1'b0;
        step(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aha_clk_gate_ctrl.md
AHA_CLK_GATE_CTRL -- requirements
Module: aha_clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_W, default 8, width of the idle-timeout count.
REQ-002 SHALL have parameter CNT_W, default 16, width of the gated-cycle statistics counter.
REQ-003 SHALL have port CLK  input  1  single free-running clock; all state is clocked on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ACTIVE  input  1  gated domain busy; sampled only while the domain clock runs.
REQ-006 SHALL have port WAKE_REQ  input  1  level wake request from an always-on source.
REQ-007 SHALL have port FORCE_ON  input  1  software override; while high, gating is inhibited.
REQ-008 SHALL have port IDLE_LIMIT  input  IDLE_W  idle cycles required before a stop request.
REQ-009 SHALL have port STOP_ACK  input  1  domain acknowledges quiescence (4-phase with STOP_REQ).
REQ-010 SHALL have port TEST_EN  input  1  scan test enable.
REQ-011 SHALL have port STOP_REQ  output  1  registered request for the domain to quiesce.
REQ-012 SHALL have port GATE_EN  output  1  registered enable driving the ICG E pin.
REQ-013 SHALL have port GATE_TE  output  1  combinational copy of TEST_EN driving the ICG TE pin.
REQ-014 SHALL have port CLK_GATED  output  1  high exactly while the FSM is in GATED.
REQ-015 SHALL have port GATED_CNT  output  CNT_W  count of cycles spent in GATED, saturating.

Function
REQ-016 SHALL implement FSM states RUN, IDLE, REQ, GATED, WAKE; "wake" below means WAKE_REQ|FORCE_ON.
REQ-017 RUN: GATE_EN=1, STOP_REQ=0; if !ACTIVE && !wake, load counter with IDLE_LIMIT and go to IDLE; otherwise stay in RUN.
REQ-018 IDLE: counter decrements by 1 per cycle; ACTIVE or wake returns the FSM to RUN next cycle; when the counter equals 0 and no ACTIVE/wake, go to REQ; IDLE_LIMIT=0 reaches REQ one cycle after entering IDLE.
REQ-019 REQ: STOP_REQ=1, GATE_EN=1; wake or ACTIVE goes to WAKE (wins over STOP_ACK in the same cycle); otherwise STOP_ACK=1 goes to GATED.
REQ-020 GATED: GATE_EN=0, STOP_REQ=1, ACTIVE ignored; wake goes to WAKE.
REQ-021 WAKE: GATE_EN=1, STOP_REQ=0; STOP_ACK=0 goes to RUN; otherwise hold in WAKE.
REQ-022 Outputs SHALL be registered from next-state; GATE_EN changes on the clock edge on which the FSM enters/leaves GATED (one-cycle latency from input to GATE_EN).
REQ-023 IDLE_LIMIT SHALL be sampled only on the RUN->IDLE transition; changes during IDLE have no effect.
REQ-024 GATED_CNT SHALL increment by 1 each cycle CLK_GATED=1, saturating at all-ones, never wrapping.
REQ-025 GATE_TE SHALL equal TEST_EN at all times, including during reset.
REQ-026 FORCE_ON held high SHALL keep the FSM in RUN, or drive it to RUN via WAKE within at most 2 cycles plus the STOP_ACK release time.

Reset
REQ-027 RESET high SHALL asynchronously force state RUN, GATE_EN=1, STOP_REQ=0, CLK_GATED=0, counter=0, GATED_CNT=0.
REQ-028 RESET asserted mid-handshake (REQ, GATED or WAKE) SHALL drop STOP_REQ immediately; on release, the FSM restarts in RUN regardless of STOP_ACK.
REQ-029 The first state transition after reset deassertion SHALL occur no earlier than the first rising CLK edge.

Verification
REQ-030 IDLE_LIMIT=4, ACTIVE=0, STOP_ACK returned 1 cycle after STOP_REQ -> STOP_REQ rises 6 cycles after reset release, GATE_EN=0 the cycle after STOP_ACK, GATED_CNT counts up.
REQ-031 In IDLE with counter=2, pulse ACTIVE for 1 cycle -> return to RUN, STOP_REQ never asserts, full IDLE_LIMIT reload on the next idle.
REQ-032 In REQ, assert WAKE_REQ and STOP_ACK in the same cycle -> WAKE entered, GATE_EN stays 1, STOP_REQ falls; RUN entered after STOP_ACK falls.
REQ-033 In GATED, assert WAKE_REQ -> GATE_EN=1 next cycle, STOP_REQ=0; STOP_ACK released 3 cycles later -> RUN; CLK_GATED low from the WAKE entry.
REQ-034 CNT_W=4, hold GATED for 20 cycles -> GATED_CNT saturates at 15; FORCE_ON=1 throughout a separate run -> GATE_EN never drops.
REQ-035 Assert RESET while in GATED -> GATE_EN=1 and STOP_REQ=0 without a CLK edge; toggle TEST_EN during reset -> GATE_TE follows it.
